// File: rtl/icache_line_fetcher_if.sv
// Bundles the I-cache miss port and the narrow memory-bus port of the line fetcher.
// Latency: none; wires only.
// Backpressure: the memory side stalls through m_ready_i; the cache side holds c_strobe_i until c_ready_o.
interface icache_line_fetcher_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_SIZE  = 256,
  parameter int BUS_WIDTH  = 32
);
  logic                  c_strobe_i;
  logic [ADDR_WIDTH-1:0] c_addr_i;
  logic                  c_ready_o;
  logic [LINE_SIZE-1:0]  c_data_o;
  logic                  m_strobe_o;
  logic [ADDR_WIDTH-1:0] m_addr_o;
  logic                  m_ready_i;
  logic [BUS_WIDTH-1:0]  m_data_i;

  // Requester / memory-model side: drives the fetcher's inputs.
  modport master (
    output c_strobe_i, c_addr_i, m_ready_i, m_data_i,
    input  c_ready_o, c_data_o, m_strobe_o, m_addr_o
  );

  // Fetcher side.
  modport slave (
    input  c_strobe_i, c_addr_i, m_ready_i, m_data_i,
    output c_ready_o, c_data_o, m_strobe_o, m_addr_o
  );
endinterface

// File: rtl/icache_line_fetcher.sv
// Splits one I-cache line fill into BEATS single-outstanding bus reads and reassembles the line.
// Latency: BEATS+1 cycles from request to c_ready_o pulse with no stalls (1 cycle on a last-line hit).
// Backpressure: each beat waits on m_ready_i with m_addr_o held stable; requester holds c_strobe_i until c_ready_o.
// Optional last-line buffer enabled by defining LAST_LINE_BUFFER_EN.
module icache_line_fetcher #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_SIZE  = 256,
  parameter int BUS_WIDTH  = 32
) (
  input logic                 clk_i,
  input logic                 rst_i,
  icache_line_fetcher_if.slave bus
);

  localparam int BEATS     = LINE_SIZE / BUS_WIDTH;
  localparam int WPB       = BUS_WIDTH / 32;
  localparam int WORDS     = LINE_SIZE / 32;
  localparam int CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0]      LAST_BEAT  = CNT_W'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(BUS_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK  = ~ADDR_WIDTH'(LINE_SIZE / 8 - 1);

  typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  c_ready_q, c_ready_d;
  logic [LINE_SIZE-1:0]  c_data_q, c_data_d;
  logic                  m_strobe_q, m_strobe_d;
  logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
  logic [ADDR_WIDTH-1:0] req_base;
  logic                  hit;
`ifdef LAST_LINE_BUFFER_EN
  logic [ADDR_WIDTH-1:0] tag_q, tag_d;
  logic                  tag_vld_q, tag_vld_d;
`endif

  assign req_base       = bus.c_addr_i & LINE_MASK;
  assign bus.c_ready_o  = c_ready_q;
  assign bus.c_data_o   = c_data_q;
  assign bus.m_strobe_o = m_strobe_q;
  assign bus.m_addr_o   = m_addr_q;

  // Next-state and next-output logic; every output is the registered copy of a *_d value.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    c_ready_d  = 1'b0;
    c_data_d   = c_data_q;
    m_strobe_d = m_strobe_q;
    m_addr_d   = m_addr_q;
    hit        = 1'b0;
`ifdef LAST_LINE_BUFFER_EN
    tag_d      = tag_q;
    tag_vld_d  = tag_vld_q;
    hit        = tag_vld_q && (tag_q == req_base);
`endif
    case (state_q)
      IDLE: begin
        if (bus.c_strobe_i) begin
          if (hit) begin
            // Line already assembled in c_data_q: answer without touching the bus.
            state_d   = DONE;
            c_ready_d = 1'b1;
          end else begin
            state_d    = BEAT;
            m_addr_d   = req_base;
            m_strobe_d = 1'b1;
            cnt_d      = '0;
          end
        end
      end
      BEAT: begin
        if (bus.m_ready_i) begin
          // Beat k carries line words k*WPB..k*WPB+WPB-1; word 0 sits at the top of the line.
          for (int n = 0; n < WORDS; n++) begin
            if (CNT_W'(n / WPB) == cnt_q) begin
              c_data_d[LINE_SIZE-1-32*n -: 32] = bus.m_data_i[32*(n % WPB) +: 32];
            end
          end
          if (cnt_q == LAST_BEAT) begin
            state_d    = DONE;
            m_strobe_d = 1'b0;
            m_addr_d   = '0;
            c_ready_d  = 1'b1;
`ifdef LAST_LINE_BUFFER_EN
            tag_d      = m_addr_q & LINE_MASK;
            tag_vld_d  = 1'b1;
`endif
          end else begin
            cnt_d    = cnt_q + 1'b1;
            m_addr_d = m_addr_q + BEAT_BYTES;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any fill in progress and drops partial data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      c_ready_q  <= 1'b0;
      c_data_q   <= '0;
      m_strobe_q <= 1'b0;
      m_addr_q   <= '0;
`ifdef LAST_LINE_BUFFER_EN
      tag_q      <= '0;
      tag_vld_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      c_ready_q  <= c_ready_d;
      c_data_q   <= c_data_d;
      m_strobe_q <= m_strobe_d;
      m_addr_q   <= m_addr_d;
`ifdef LAST_LINE_BUFFER_EN
      tag_q      <= tag_d;
      tag_vld_q  <= tag_vld_d;
`endif
    end
  end

endmodule

// File: tb/tb_icache_line_fetcher.sv
// Directed bench for the line fetcher: a 32-bit bus instance and a 128-bit bus instance.
// Latency: checked per fill against hand-derived cycle counts.
// Backpressure: memory model inserts random 0-5 cycle stalls per beat in the stall section.
module tb_icache_line_fetcher;

  logic clk_i = 1'b0;
  logic rst_i;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk_i = ~clk_i;

  icache_line_fetcher_if #(.ADDR_WIDTH(32), .LINE_SIZE(256), .BUS_WIDTH(32))  b32 ();
  icache_line_fetcher_if #(.ADDR_WIDTH(32), .LINE_SIZE(256), .BUS_WIDTH(128)) b128 ();

  icache_line_fetcher #(.ADDR_WIDTH(32), .LINE_SIZE(256), .BUS_WIDTH(32)) dut32 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (b32)
  );

  icache_line_fetcher #(.ADDR_WIDTH(32), .LINE_SIZE(256), .BUS_WIDTH(128)) dut128 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (b128)
  );

  // Memory contents: every aligned word address maps to a distinct pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1234_5678;
  endfunction

  // Expected line: word n of the line (address base+4n) at bits [255-32n -: 32].
  function automatic logic [255:0] exp_line(input logic [31:0] a);
    logic [31:0]  base;
    logic [255:0] l;
    base = {a[31:5], 5'b0};
    l    = '0;
    for (int n = 0; n < 8; n++) l[255-32*n -: 32] = mem_word(base + 32'(4*n));
    return l;
  endfunction

  always_comb b32.m_data_i = mem_word(b32.m_addr_o);
  always_comb b128.m_data_i = {mem_word(b128.m_addr_o + 32'd12), mem_word(b128.m_addr_o + 32'd8),
                               mem_word(b128.m_addr_o + 32'd4),  mem_word(b128.m_addr_o)};

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One fill on the 32-bit instance; exp_lat < 0 skips the latency check (stalled runs).
  task automatic fill32(input string tag, input logic [31:0] addr, input int stall_max,
                        input int exp_lat, input int exp_beats);
    int n = 0, lat = -1, nb = 0, np = 0, post = 0, nstrb = 0, post_strb = 0, bad_stable = 0, stall;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] base;
    base  = {addr[31:5], 5'b0};
    stall = int'($urandom_range(stall_max, 0));
    b32.c_addr_i   = addr;
    b32.c_strobe_i = 1'b1;
    while (n < 300 && post < 4) begin
      @(negedge clk_i);
      n++;
      if (lat >= 0) post++;
      if (b32.c_ready_o) begin
        np++;
        if (lat < 0) begin
          lat = n;
          b32.c_strobe_i = 1'b0;
        end
      end
      if (b32.m_strobe_o) begin
        nstrb++;
        if (lat >= 0) post_strb++;
      end
      if (prev_hold && b32.m_strobe_o && (b32.m_addr_o !== prev_addr)) bad_stable++;
      if (lat >= 0) b32.m_ready_i = 1'b1;
      else if (stall > 0) begin
        b32.m_ready_i = 1'b0;
        stall--;
      end else b32.m_ready_i = 1'b1;
      if (b32.m_strobe_o && b32.m_ready_i) begin
        chk({tag, " beat addr"}, 256'(b32.m_addr_o), 256'(base + 32'(4*nb)));
        nb++;
        stall = int'($urandom_range(stall_max, 0));
      end
      prev_hold = b32.m_strobe_o && !b32.m_ready_i;
      prev_addr = b32.m_addr_o;
    end
    b32.c_strobe_i = 1'b0;
    b32.m_ready_i  = 1'b0;
    if (exp_lat >= 0) chk({tag, " latency"}, 256'(lat), 256'(exp_lat));
    else chk({tag, " completed"}, 256'(lat > 0), 256'(1));
    chk({tag, " beats"}, 256'(nb), 256'(exp_beats));
    chk({tag, " ready pulses"}, 256'(np), 256'(1));
    chk({tag, " strobe after done"}, 256'(post_strb), 256'(0));
    chk({tag, " strobe seen"}, 256'(nstrb != 0), 256'(exp_beats != 0));
    chk({tag, " addr stable in stall"}, 256'(bad_stable), 256'(0));
    chk({tag, " line"}, b32.c_data_o, exp_line(addr));
  endtask

  task automatic fill128(input logic [31:0] addr, input int exp_lat);
    int n = 0, lat = -1, nb = 0, np = 0, post = 0;
    logic [31:0] base;
    base = {addr[31:5], 5'b0};
    b128.c_addr_i   = addr;
    b128.c_strobe_i = 1'b1;
    b128.m_ready_i  = 1'b1;
    while (n < 50 && post < 3) begin
      @(negedge clk_i);
      n++;
      if (lat >= 0) post++;
      if (b128.c_ready_o) begin
        np++;
        if (lat < 0) begin
          lat = n;
          b128.c_strobe_i = 1'b0;
        end
      end
      if (b128.m_strobe_o) begin
        chk("w128 beat addr", 256'(b128.m_addr_o), 256'(base + 32'(16*nb)));
        nb++;
      end
    end
    b128.c_strobe_i = 1'b0;
    b128.m_ready_i  = 1'b0;
    chk("w128 latency", 256'(lat), 256'(exp_lat));
    chk("w128 beats", 256'(nb), 256'(2));
    chk("w128 ready pulses", 256'(np), 256'(1));
    chk("w128 line", b128.c_data_o, exp_line(addr));
  endtask

  initial begin
    int np;
    rst_i = 1'b1;
    b32.c_strobe_i  = 1'b0; b32.c_addr_i  = '0; b32.m_ready_i  = 1'b0;
    b128.c_strobe_i = 1'b0; b128.c_addr_i = '0; b128.m_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst c_ready", 256'(b32.c_ready_o), 256'(0));
    chk("rst c_data", b32.c_data_o, 256'(0));
    chk("rst m_strobe", 256'(b32.m_strobe_o), 256'(0));
    chk("rst m_addr", 256'(b32.m_addr_o), 256'(0));
    chk("rst w128 m_strobe", 256'(b128.m_strobe_o), 256'(0));
    chk("rst w128 c_data", b128.c_data_o, 256'(0));
    rst_i = 1'b0;

    // m_ready_i pulsed in IDLE with no request: nothing happens.
    b32.m_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("idle m_strobe", 256'(b32.m_strobe_o), 256'(0));
    chk("idle c_data", b32.c_data_o, 256'(0));
    b32.m_ready_i = 1'b0;

    // Unaligned request, no stalls: 8 beats from the line base, 9-cycle latency.
    fill32("basic", 32'h8000_0014, 0, 9, 8);
    chk("basic word0 top", 256'(b32.c_data_o[255:224]), 256'(mem_word(32'h8000_0000)));
    chk("basic word7 bottom", 256'(b32.c_data_o[31:0]), 256'(mem_word(32'h8000_001C)));

    // m_ready_i held high in IDLE after the fill: line held, no new bus activity.
    b32.m_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("post idle m_strobe", 256'(b32.m_strobe_o), 256'(0));
    chk("post idle line hold", b32.c_data_o, exp_line(32'h8000_0000));
    b32.m_ready_i = 1'b0;

    // 128-bit bus: two beats, 3-cycle latency.
    fill128(32'h1000_0028, 3);

    // Random stalls on each beat.
    for (int i = 0; i < 3; i++) fill32("stall", 32'h4000_0100 + 32'(36*i), 5, -1, 8);

    // Reset after three beats have been captured.
    @(negedge clk_i);
    b32.c_addr_i   = 32'h8000_0080;
    b32.c_strobe_i = 1'b1;
    b32.m_ready_i  = 1'b1;
    repeat (4) @(negedge clk_i);
    chk("abort mid m_strobe", 256'(b32.m_strobe_o), 256'(1));
    chk("abort mid m_addr", 256'(b32.m_addr_o), 256'(32'h8000_008C));
    rst_i          = 1'b1;
    b32.c_strobe_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("abort m_strobe", 256'(b32.m_strobe_o), 256'(0));
    chk("abort c_data", b32.c_data_o, 256'(0));
    np = 0;
    repeat (5) begin
      @(negedge clk_i);
      if (b32.c_ready_o) np++;
    end
    chk("abort no ready", 256'(np), 256'(0));
    b32.m_ready_i = 1'b0;
    fill32("refetch", 32'h8000_0080, 0, 9, 8);

    // Last-line buffer: repeat request to the same line.
    fill32("llb first", 32'h8000_0040, 0, 9, 8);
`ifdef LAST_LINE_BUFFER_EN
    fill32("llb hit", 32'h8000_004C, 0, 1, 0);
`else
    fill32("llb same line", 32'h8000_004C, 0, 9, 8);
`endif
    fill32("llb miss", 32'h8000_0060, 0, 9, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
